// File: rtl/regfile_ctx_ctrl.sv
// Context save/restore sequencer: walks FIRST_REG..LAST_REG, copying registers to a
// contiguous memory block (save) or reloading them from it (restore) while the CPU is stalled.
module regfile_ctx_ctrl #(
  parameter int n         = 32,
  parameter int r         = 5,
  parameter int FIRST_REG = 1,
  parameter int LAST_REG  = 31
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         save_req,
  input  logic         restore_req,
  input  logic [n-1:0] base_addr,
  output logic         busy,
  output logic         done,
  output logic [r-1:0] rf_ra,
  input  logic [n-1:0] rf_rd,
  output logic         rf_we,
  output logic [r-1:0] rf_wa,
  output logic [n-1:0] rf_wd,
  output logic         mem_req,
  output logic         mem_we,
  output logic [n-1:0] mem_addr,
  output logic [n-1:0] mem_wdata,
  input  logic [n-1:0] mem_rdata,
  input  logic         mem_ack
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] SAVE_RD = 3'd1;
  localparam logic [2:0] SAVE_WR = 3'd2;
  localparam logic [2:0] REST_RD = 3'd3;
  localparam logic [2:0] REST_WR = 3'd4;
  localparam logic [2:0] DONE    = 3'd5;

  localparam logic [r-1:0] FIRST_IDX = r'(FIRST_REG);
  localparam logic [r-1:0] LAST_IDX  = r'(LAST_REG);

  logic [2:0]   state_reg, state_next;
  logic [r-1:0] idx_reg, idx_next;
  logic [n-1:0] base_reg, base_next;
  logic [n-1:0] data_reg, data_next;
  logic [r-1:0] slot;
  logic [n-1:0] blk_addr;
  logic         last_idx;

  // Word slot within the context block; the sum wraps naturally at 2**n.
  assign slot     = idx_reg - FIRST_IDX;
  assign blk_addr = base_reg + (n'(slot) << 2);
  assign last_idx = (idx_reg == LAST_IDX);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      idx_reg   <= '0;
      base_reg  <= '0;
      data_reg  <= '0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
      base_reg  <= base_next;
      data_reg  <= data_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    base_next  = base_reg;
    data_next  = data_reg;
    busy       = 1'b0;
    done       = 1'b0;
    rf_ra      = '0;
    rf_we      = 1'b0;
    rf_wa      = '0;
    rf_wd      = '0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    case (state_reg)
      IDLE: begin
        // Save has priority; a simultaneous restore request is simply dropped.
        if (save_req) begin
          base_next  = base_addr;
          idx_next   = FIRST_IDX;
          state_next = SAVE_RD;
        end else if (restore_req) begin
          base_next  = base_addr;
          idx_next   = FIRST_IDX;
          state_next = REST_RD;
        end
      end
      SAVE_RD: begin
        busy       = 1'b1;
        rf_ra      = idx_reg;
        data_next  = rf_rd;
        state_next = SAVE_WR;
      end
      SAVE_WR: begin
        busy      = 1'b1;
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = blk_addr;
        mem_wdata = data_reg;
        if (mem_ack) begin
          if (last_idx) begin
            state_next = DONE;
          end else begin
            idx_next   = idx_reg + 1'b1;
            state_next = SAVE_RD;
          end
        end
      end
      REST_RD: begin
        busy     = 1'b1;
        mem_req  = 1'b1;
        mem_addr = blk_addr;
        if (mem_ack) begin
          data_next  = mem_rdata;
          state_next = REST_WR;
        end
      end
      REST_WR: begin
        // idx never drops below FIRST_REG (>= 1), so r0 is never the target.
        busy  = 1'b1;
        rf_we = 1'b1;
        rf_wa = idx_reg;
        rf_wd = data_reg;
        if (last_idx) begin
          state_next = DONE;
        end else begin
          idx_next   = idx_reg + 1'b1;
          state_next = REST_RD;
        end
      end
      DONE: begin
        busy       = 1'b1;
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_regfile_ctx_ctrl.sv
// Scoreboard bench for regfile_ctx_ctrl: stimulus pushes expected transactions,
// negedge monitors pop and compare memory accesses, regfile writes and done latency.
module tb_regfile_ctx_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        save_req, restore_req;
  logic [31:0] base_addr;
  logic        busy, done;
  logic [4:0]  rf_ra, rf_wa;
  logic [31:0] rf_rd, rf_wd;
  logic        rf_we;
  logic        mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  logic        save_req2;
  logic [31:0] base_addr2;
  logic        busy2, done2;
  logic [4:0]  rf_ra2, rf_wa2;
  logic [31:0] rf_rd2, rf_wd2;
  logic        rf_we2;
  logic        mem_req2, mem_we2, mem_ack2;
  logic [31:0] mem_addr2, mem_wdata2;
  logic [31:0] mem_rdata2;

  always #5 clk = ~clk;

  regfile_ctx_ctrl dut (
    .clk(clk), .rst_n(rst_n), .save_req(save_req), .restore_req(restore_req),
    .base_addr(base_addr), .busy(busy), .done(done), .rf_ra(rf_ra), .rf_rd(rf_rd),
    .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  regfile_ctx_ctrl #(.n(32), .r(5), .FIRST_REG(1), .LAST_REG(4)) dut2 (
    .clk(clk), .rst_n(rst_n), .save_req(save_req2), .restore_req(1'b0),
    .base_addr(base_addr2), .busy(busy2), .done(done2), .rf_ra(rf_ra2), .rf_rd(rf_rd2),
    .rf_we(rf_we2), .rf_wa(rf_wa2), .rf_wd(rf_wd2), .mem_req(mem_req2), .mem_we(mem_we2),
    .mem_addr(mem_addr2), .mem_wdata(mem_wdata2), .mem_rdata(mem_rdata2), .mem_ack(mem_ack2)
  );

  // Regfile and memory models shared by both instances.
  logic [31:0] rf [32];
  logic [31:0] mem [128];
  logic        rf_load, mem_load;
  int          mem_wait, wait_cnt, cyc;

  assign rf_rd      = rf[rf_ra];
  assign rf_rd2     = rf[rf_ra2];
  assign mem_rdata  = mem[mem_addr[8:2]];
  assign mem_ack    = mem_req && (wait_cnt == mem_wait);
  assign mem_ack2   = mem_req2;
  assign mem_rdata2 = 32'h0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    wait_cnt <= (mem_req && !mem_ack) ? wait_cnt + 1 : 0;
    if (rf_load) begin
      for (int k = 0; k < 32; k++) rf[k] <= (k == 0) ? 32'h0 : 32'h100 + k;
    end else if (rf_we) begin
      rf[rf_wa] <= rf_wd;
    end
    if (mem_load) begin
      for (int k = 0; k < 128; k++) mem[k] <= 32'hDEAD_0000;
      for (int k = 1; k <= 31; k++) mem[63 + k] <= 32'hA000 + k;
    end else if (mem_req && mem_ack && mem_we) begin
      mem[mem_addr[8:2]] <= mem_wdata;
    end
  end

  typedef struct {
    int          kind;   // 0 mem write, 1 mem read, 2 rf write, 3 done (data = latency)
    logic [31:0] addr;
    logic [31:0] data;
  } exp_t;

  exp_t q1[$];
  exp_t q2[$];
  exp_t e1, e2;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   req_cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic push(input int sel, input int kind, input logic [31:0] addr, input logic [31:0] data);
    exp_t t;
    t.kind = kind; t.addr = addr; t.data = data;
    if (sel == 1) q1.push_back(t); else q2.push_back(t);
  endtask

  // Monitor for the main instance.
  logic        prev_wait = 1'b0;
  logic [31:0] prev_addr, prev_wdata;
  logic        prev_we;
  always @(negedge clk) begin
    if (prev_wait && mem_req) begin
      check("hold_addr", mem_addr, prev_addr);
      check("hold_we", {31'b0, mem_we}, {31'b0, prev_we});
      check("hold_wdata", mem_wdata, prev_wdata);
    end
    prev_wait  = mem_req && !mem_ack;
    prev_addr  = mem_addr;
    prev_we    = mem_we;
    prev_wdata = mem_wdata;
    if (mem_req && mem_ack) begin
      if (q1.size() == 0) begin
        check("unexpected_mem_access", mem_addr, 32'hFFFF_FFFF);
      end else begin
        e1 = q1.pop_front();
        check("mem_kind", {31'b0, ~mem_we}, e1.kind);
        check("mem_addr", mem_addr, e1.addr);
        if (mem_we) check("mem_wdata", mem_wdata, e1.data);
        else        check("mem_rdata", mem_rdata, e1.data);
        $display("mem  we=%0d addr=%h data=%h", mem_we, mem_addr, mem_we ? mem_wdata : mem_rdata);
      end
    end
    if (rf_we) begin
      check("rf_wa_nonzero", {31'b0, rf_wa == 5'd0}, 32'h0);
      if (q1.size() == 0) begin
        check("unexpected_rf_write", {27'b0, rf_wa}, 32'hFFFF_FFFF);
      end else begin
        e1 = q1.pop_front();
        check("rf_kind", 32'd2, e1.kind);
        check("rf_wa", {27'b0, rf_wa}, e1.addr);
        check("rf_wd", rf_wd, e1.data);
        $display("rf   wa=%0d data=%h", rf_wa, rf_wd);
      end
    end
    if (done) begin
      check("busy_at_done", {31'b0, busy}, 32'h1);
      if (q1.size() == 0) begin
        check("unexpected_done", cyc - req_cyc, 32'hFFFF_FFFF);
      end else begin
        e1 = q1.pop_front();
        check("done_kind", 32'd3, e1.kind);
        check("done_latency", cyc - req_cyc, e1.data);
        $display("done latency=%0d", cyc - req_cyc);
      end
    end
  end

  // Monitor for the short-range wrap instance.
  always @(negedge clk) begin
    if (mem_req2 && mem_ack2) begin
      if (q2.size() == 0) begin
        check("unexpected_mem_access2", mem_addr2, 32'hFFFF_FFFF);
      end else begin
        e2 = q2.pop_front();
        check("mem2_kind", {31'b0, ~mem_we2}, e2.kind);
        check("mem2_addr", mem_addr2, e2.addr);
        check("mem2_wdata", mem_wdata2, e2.data);
        $display("mem2 we=%0d addr=%h data=%h", mem_we2, mem_addr2, mem_wdata2);
      end
    end
    if (done2) begin
      if (q2.size() == 0) begin
        check("unexpected_done2", cyc - req_cyc, 32'hFFFF_FFFF);
      end else begin
        e2 = q2.pop_front();
        check("done2_latency", cyc - req_cyc, e2.data);
        $display("done2 latency=%0d", cyc - req_cyc);
      end
    end
  end

  task automatic start(input int sel, input logic sv, input logic rs, input logic [31:0] base);
    @(negedge clk);
    if (sel == 1) begin
      save_req = sv; restore_req = rs; base_addr = base;
    end else begin
      save_req2 = sv; base_addr2 = base;
    end
    @(posedge clk);
    #1 req_cyc = cyc;
    @(negedge clk);
    save_req = 1'b0; restore_req = 1'b0; save_req2 = 1'b0;
  endtask

  task automatic wait_quiet(input int max, input string name);
    int i = 0;
    do begin
      @(negedge clk); #2;
      i++;
    end while ((busy || busy2 || q1.size() != 0 || q2.size() != 0) && i < max);
    check({name, "_timeout"}, {31'b0, i >= max}, 32'h0);
    check({name, "_queue_empty"}, q1.size() + q2.size(), 32'h0);
  endtask

  initial begin
    int cnt;
    cyc = 0; mem_wait = 0;
    rst_n = 1'b0; save_req = 1'b1; restore_req = 1'b0; base_addr = 32'h0;
    save_req2 = 1'b0; base_addr2 = 32'h0;
    rf_load = 1'b1; mem_load = 1'b1;

    // Reset held for two edges with save_req high.
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      rf_load = 1'b0; mem_load = 1'b0;
      check("rst_busy", {31'b0, busy}, 32'h0);
      check("rst_done", {31'b0, done}, 32'h0);
      check("rst_mem_req", {31'b0, mem_req}, 32'h0);
      check("rst_rf_we", {31'b0, rf_we}, 32'h0);
      check("rst_mem_addr", mem_addr, 32'h0);
    end
    save_req = 1'b0; rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_after_rst", {31'b0, busy}, 32'h0);

    // Save with zero-wait memory; a second save_req mid-sequence must be ignored.
    mem_wait = 0;
    for (int k = 1; k <= 31; k++) push(1, 0, 32'h80 + 4 * (k - 1), 32'h100 + k);
    push(1, 3, 0, 62);
    start(1, 1'b1, 1'b0, 32'h80);
    repeat (20) @(negedge clk);
    save_req = 1'b1;
    @(negedge clk);
    save_req = 1'b0;
    wait_quiet(200, "save");

    // Restore with two wait cycles per access.
    mem_wait = 2;
    for (int k = 1; k <= 31; k++) begin
      push(1, 1, 32'h100 + 4 * (k - 1), 32'hA000 + k);
      push(1, 2, k, 32'hA000 + k);
    end
    push(1, 3, 0, 124);
    start(1, 1'b0, 1'b1, 32'h100);
    wait_quiet(400, "restore");
    for (int k = 1; k <= 31; k++) check($sformatf("rf_%0d", k), rf[k], 32'hA000 + k);
    check("rf_0", rf[0], 32'h0);

    // Simultaneous requests: only the save runs.
    mem_wait = 0;
    for (int k = 1; k <= 31; k++) push(1, 0, 32'h80 + 4 * (k - 1), 32'hA000 + k);
    push(1, 3, 0, 62);
    start(1, 1'b1, 1'b1, 32'h80);
    wait_quiet(200, "both");
    cnt = 0;
    repeat (10) begin
      @(negedge clk);
      if (busy) cnt++;
    end
    check("no_restore_after_both", cnt, 32'h0);

    // Reset while SAVE_WR of idx 10 waits for its ack.
    mem_wait = 2;
    for (int k = 1; k <= 9; k++) push(1, 0, 32'h180 + 4 * (k - 1), 32'hA000 + k);
    start(1, 1'b1, 1'b0, 32'h180);
    cnt = 0;
    while (!(mem_req && mem_addr == 32'h1A4) && cnt < 400) begin
      @(negedge clk);
      cnt++;
    end
    check("reach_idx10_timeout", {31'b0, cnt >= 400}, 32'h0);
    rst_n = 1'b0;
    @(negedge clk);
    check("abort_busy", {31'b0, busy}, 32'h0);
    rst_n = 1'b1;
    cnt = 0;
    repeat (20) begin
      @(negedge clk);
      if (mem_req || rf_we) cnt++;
    end
    check("no_req_after_abort", cnt, 32'h0);
    check("abort_queue_empty", q1.size(), 32'h0);
    for (int k = 1; k <= 9; k++)   check($sformatf("abort_mem_%0d", k), mem[95 + k], 32'hA000 + k);
    for (int k = 10; k <= 31; k++) check($sformatf("abort_mem_%0d", k), mem[95 + k], 32'hDEAD_0000);

    // Address wrap on the four-register instance.
    push(2, 0, 32'hFFFF_FFF8, 32'hA001);
    push(2, 0, 32'hFFFF_FFFC, 32'hA002);
    push(2, 0, 32'h0000_0000, 32'hA003);
    push(2, 0, 32'h0000_0004, 32'hA004);
    push(2, 3, 0, 8);
    start(2, 1'b1, 1'b0, 32'hFFFF_FFF8);
    wait_quiet(50, "wrap");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, %0d compared so far", n_cmp);
    $fatal(1);
  end

endmodule
